// File: rtl/cia_pkg.sv
// Shared definitions for the pipelined carry-increment adder.
// Holds the default geometry, the slice-width helper and the reference layout
// of one pipeline stage payload at the default width.
package cia_pkg;

    localparam int unsigned DefWidth  = 32;
    localparam int unsigned DefBlk    = 4;
    localparam int unsigned DefStages = 4;

    // Bits handled by each pipeline slice.
    function automatic int unsigned slice_w(input int unsigned width, input int unsigned stages);
        return width / stages;
    endfunction

    // Stage payload at default width. The top declares the same layout sized
    // by its own parameters.
    typedef struct packed {
        logic [DefWidth-1:0] psum;    // completed sum bits, slices 0..k
        logic                carry;   // carry out of slice k
        logic [DefWidth-1:0] rem_a;   // operand A (upper slices still pending)
        logic [DefWidth-1:0] rem_be;  // effective operand B
        logic                a_msb;   // MSB of A, kept for overflow
        logic                be_msb;  // MSB of effective B, kept for overflow
    } stage_pay_t;

endpackage

// File: rtl/cia_slice.sv
// Combinational carry-increment adder slice.
// Each BLK-bit block is summed with carry-in 0, then incremented by the
// carry arriving from the block below.
// Ports:
//   a, b  - SW-bit operands
//   cin   - carry into bit 0
//   sum   - SW-bit result
//   cout  - carry out of the top bit
module cia_slice #(
    parameter int unsigned SW  = 8,
    parameter int unsigned BLK = 4
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout
);

    localparam int unsigned NB = SW / BLK;

    logic [NB:0] c;

    assign c[0] = cin;

    for (genvar g = 0; g < NB; g++) begin : g_blk
        logic [BLK:0] raw;

        assign raw = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]};
        assign sum[g*BLK +: BLK] = raw[BLK-1:0] + BLK'(c[g]);
        // Incoming carry ripples through only when the raw block sum is all ones.
        assign c[g+1] = raw[BLK] | (c[g] & (&raw[BLK-1:0]));
    end

    assign cout = c[NB];

endmodule

// File: rtl/cia_pipe_adder.sv
// Pipelined carry-increment adder/subtractor with valid/ready handshake.
// Slice k of the operands is summed in stage k; every stage can stall
// independently and empty stages are filled even while later ones stall.
// Ports:
//   clk, rst_n          - clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  - operand handshake
//   a, b, cin, sub      - operands, carry in, subtract select
//   out_valid, out_ready- result handshake
//   sum, cout, ovf      - result, carry out (inverted borrow when sub), signed overflow
module cia_pipe_adder
    import cia_pkg::*;
#(
    parameter int unsigned WIDTH  = DefWidth,
    parameter int unsigned BLK    = DefBlk,
    parameter int unsigned STAGES = DefStages
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned SW = slice_w(WIDTH, STAGES);

    if ((WIDTH % (STAGES * BLK)) != 0) begin : g_bad_cfg
        $error("cia_pipe_adder: WIDTH must be a multiple of STAGES*BLK");
    end

    typedef struct packed {
        logic [WIDTH-1:0] psum;
        logic             carry;
        logic [WIDTH-1:0] rem_a;
        logic [WIDTH-1:0] rem_be;
        logic             a_msb;
        logic             be_msb;
    } pay_t;

    logic [WIDTH-1:0]  be;
    logic              ce;
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_up;
    logic [STAGES-1:0] adv;
    pay_t              stage_q [STAGES];
    pay_t              last;
    logic              unused_rem;

    assign be = b ^ {WIDTH{sub}};
    assign ce = cin ^ sub;

    // A stage may advance if the consumer takes the result or any stage at or
    // downstream of it is empty, which collapses bubbles.
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        adv      = '0;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            all_full = all_full & v_q[k];
            adv[k]   = out_ready | ~all_full;
        end
    end

    always_comb begin
        v_up    = '0;
        v_up[0] = in_valid;
        for (int k = 1; k < int'(STAGES); k++) begin
            v_up[k] = v_q[k-1];
        end
    end

    assign in_ready = adv[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (adv[k]) begin
                    v_q[k] <= v_up[k];
                end
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SW-1:0] op_a;
        logic [SW-1:0] op_b;
        logic [SW-1:0] s;
        logic          ci;
        logic          co;
        pay_t          base;
        pay_t          d;
        pay_t          q;

        if (k == 0) begin : g_first
            assign op_a = a[SW-1:0];
            assign op_b = be[SW-1:0];
            assign ci   = ce;
            always_comb begin
                base        = '0;
                base.rem_a  = a;
                base.rem_be = be;
                base.a_msb  = a[WIDTH-1];
                base.be_msb = be[WIDTH-1];
            end
        end else begin : g_next
            assign op_a = stage_q[k-1].rem_a[k*SW +: SW];
            assign op_b = stage_q[k-1].rem_be[k*SW +: SW];
            assign ci   = stage_q[k-1].carry;
            assign base = stage_q[k-1];
        end

        cia_slice #(
            .SW  (SW),
            .BLK (BLK)
        ) u_slice (
            .a    (op_a),
            .b    (op_b),
            .cin  (ci),
            .sum  (s),
            .cout (co)
        );

        always_comb begin
            d                    = base;
            d.psum[k*SW +: SW]   = s;
            d.carry              = co;
        end

        // Payload only loads with a real beat so outputs stay at their reset
        // values until the first result arrives.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= '0;
            end else if (adv[k] && v_up[k]) begin
                q <= d;
            end
        end

        assign stage_q[k] = q;
    end

    assign last      = stage_q[STAGES-1];
    assign out_valid = v_q[STAGES-1];
    assign sum       = last.psum;
    assign cout      = last.carry;
    assign ovf       = (last.a_msb == last.be_msb) && (last.psum[WIDTH-1] != last.a_msb);

    assign unused_rem = ^{last.rem_a, last.rem_be};

endmodule
